// File: rtl/multi_alarm_fsm.sv
// -----------------------------------------------------------------------------
// multi_alarm_fsm
//
// Multi-channel alarm controller. Each enabled channel fires once when
// current_time first equals its alarm time. Fired channels wait in a pending
// set and are serviced one event at a time, lowest index first, by a
// ring/snooze FSM with a snooze limit and a ring timeout. A channel left
// ringing until the timeout gets its sticky missed flag set.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   current_time - time value from the timekeeper
//   alarm_time   - packed alarm times, channel i at [i*TIME_W +: TIME_W]
//   alarm_enable - per-channel enable
//   snooze       - level, sampled every cycle while ringing
//   dismiss      - level, sampled every cycle while ringing or snoozed
//   missed_clr   - clears every missed flag
//   alarm_ring   - buzzer drive, high while RINGING
//   ring_id      - channel currently ringing/snoozed (holds in IDLE)
//   snooze_cnt   - snoozes used in the current ring event
//   missed       - sticky per-channel "timed out unanswered" flags
// -----------------------------------------------------------------------------
module multi_alarm_fsm #(
  parameter int N_ALARMS     = 4,
  parameter int TIME_W       = 8,
  parameter int SNOOZE_CYC   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 16
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [TIME_W-1:0]                                 current_time,
  input  logic [N_ALARMS*TIME_W-1:0]                        alarm_time,
  input  logic [N_ALARMS-1:0]                               alarm_enable,
  input  logic                                              snooze,
  input  logic                                              dismiss,
  input  logic                                              missed_clr,
  output logic                                              alarm_ring,
  output logic [(N_ALARMS > 1 ? $clog2(N_ALARMS) : 1)-1:0]  ring_id,
  output logic [(MAX_SNOOZE > 0 ? $clog2(MAX_SNOOZE+1) : 1)-1:0] snooze_cnt,
  output logic [N_ALARMS-1:0]                               missed
);

  localparam int ID_W    = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int SC_W    = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int TMR_MAX = (RING_TIMEOUT > SNOOZE_CYC) ? RING_TIMEOUT : SNOOZE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [ID_W-1:0]     ring_id_q, ring_id_d;
  logic [SC_W-1:0]     snooze_cnt_q, snooze_cnt_d;
  logic [N_ALARMS-1:0] missed_q, missed_d;
  logic [N_ALARMS-1:0] pending_q, pending_d;
  logic [N_ALARMS-1:0] match_q;

  logic [N_ALARMS-1:0] raw_match;
  logic [N_ALARMS-1:0] rise;
  logic [N_ALARMS-1:0] candidates;
  logic [ID_W-1:0]     low_idx;
  logic [N_ALARMS-1:0] clear_sel;
  logic [N_ALARMS-1:0] missed_set;
  logic                abort;

  // Match detection and lowest-index selection among waiting channels.
  always_comb begin
    raw_match = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      raw_match[i] = alarm_enable[i] &&
                     (current_time == alarm_time[i*TIME_W +: TIME_W]);
    end
    rise       = raw_match & ~match_q;
    candidates = pending_q | rise;
    // Scan downward so the last hit written is the lowest set index.
    low_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (candidates[i]) low_idx = ID_W'(i);
    end
  end

  assign abort = dismiss || !alarm_enable[ring_id_q];

  // Next-state logic.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ring_id_d    = ring_id_q;
    snooze_cnt_d = snooze_cnt_q;
    clear_sel    = '0;
    missed_set   = '0;

    case (state_q)
      IDLE: begin
        if (|candidates) begin
          state_d             = RINGING;
          timer_d             = '0;
          ring_id_d           = low_idx;
          snooze_cnt_d        = '0;
          clear_sel[low_idx]  = 1'b1;
        end
      end

      RINGING: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (snooze && (snooze_cnt_q < SC_W'(MAX_SNOOZE))) begin
          state_d      = SNOOZE;
          timer_d      = '0;
          snooze_cnt_d = snooze_cnt_q + 1'b1;
        end else if (timer_q == TMR_W'(RING_TIMEOUT - 1)) begin
          state_d               = IDLE;
          timer_d               = '0;
          missed_set[ring_id_q] = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      SNOOZE: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TMR_W'(SNOOZE_CYC - 1)) begin
          state_d = RINGING;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // The channel being selected is cleared even if it rose this cycle (that
    // rise is the event being serviced); other channels' rises are kept.
    // Disabling a channel withdraws its queued event.
    pending_d = (pending_q | rise) & ~clear_sel & alarm_enable;
    // Set wins over a simultaneous clear.
    missed_d  = (missed_q & ~{N_ALARMS{missed_clr}}) | missed_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      ring_id_q    <= '0;
      snooze_cnt_q <= '0;
      missed_q     <= '0;
      pending_q    <= '0;
      match_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ring_id_q    <= ring_id_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      pending_q    <= pending_d;
      match_q      <= raw_match;
    end
  end

  // Outputs decode registered state only.
  assign alarm_ring = (state_q == RINGING);
  assign ring_id    = ring_id_q;
  assign snooze_cnt = snooze_cnt_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_multi_alarm_fsm.sv
// -----------------------------------------------------------------------------
// tb_multi_alarm_fsm
//
// Directed bench for multi_alarm_fsm with default parameters (4 channels,
// SNOOZE_CYC=5, MAX_SNOOZE=3, RING_TIMEOUT=16). Inputs change 1 time unit
// after each rising edge and outputs are observed at the same point, so every
// observation reflects the state registered at the preceding edge.
// -----------------------------------------------------------------------------
module tb_multi_alarm_fsm;

  logic        clk;
  logic        rst_n;
  logic [7:0]  current_time;
  logic [31:0] alarm_time;
  logic [3:0]  alarm_enable;
  logic        snooze;
  logic        dismiss;
  logic        missed_clr;
  logic        alarm_ring;
  logic [1:0]  ring_id;
  logic [1:0]  snooze_cnt;
  logic [3:0]  missed;

  int total = 0;
  int bad   = 0;

  multi_alarm_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .current_time (current_time),
    .alarm_time   (alarm_time),
    .alarm_enable (alarm_enable),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .missed_clr   (missed_clr),
    .alarm_ring   (alarm_ring),
    .ring_id      (ring_id),
    .snooze_cnt   (snooze_cnt),
    .missed       (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive observations (current one included) with alarm_ring at
  // the given level; bounded so a stuck output cannot hang the run.
  task automatic count_while(input logic level, output int n);
    n = 0;
    while (alarm_ring === level && n < 100) begin
      n++;
      step();
    end
  endtask

  // Steps k cycles and reports whether alarm_ring was ever seen high.
  task automatic watch_ring(input int k, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < k; i++) begin
      step();
      if (alarm_ring !== 1'b0) seen = 1'b1;
    end
  endtask

  initial begin
    int   n;
    logic seen;

    rst_n        = 1'b0;
    current_time = 8'h00;
    // ch3=0x20, ch2=0x75, ch1=0x20, ch0=0x50
    alarm_time   = {8'h20, 8'h75, 8'h20, 8'h50};
    alarm_enable = 4'b0100;
    snooze       = 1'b0;
    dismiss      = 1'b0;
    missed_clr   = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check("rst_ring", alarm_ring, 1'b0);
    check("rst_id", ring_id, 2'd0);
    check("rst_cnt", snooze_cnt, 2'd0);
    check("rst_missed", missed, 4'b0000);
    #5 rst_n = 1'b1;
    step();
    check("idle_ring", alarm_ring, 1'b0);

    // ---------------- basic fire, held match, timeout ----------------
    current_time = 8'h75;
    check("no_comb_path", alarm_ring, 1'b0);
    step();
    check("fire_ring", alarm_ring, 1'b1);
    check("fire_id", ring_id, 2'd2);
    check("fire_cnt", snooze_cnt, 2'd0);
    count_while(1'b1, n);
    check("timeout_len", n, 16);
    check("timeout_missed", missed, 4'b0100);
    watch_ring(20, seen);
    check("held_no_refire", seen, 1'b0);
    missed_clr = 1'b1;
    step();
    missed_clr = 1'b0;
    check("missed_clr", missed, 4'b0000);

    // ---------------- snooze limit ----------------
    current_time = 8'h00;
    step();
    current_time = 8'h75;
    step();
    check("sn_ring", alarm_ring, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      check("sn_low", alarm_ring, 1'b0);
      check("sn_cnt", snooze_cnt, j);
      count_while(1'b0, n);
      check("sn_window", n, 5);
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("sn4_ignored", alarm_ring, 1'b1);
    check("sn4_cnt", snooze_cnt, 2'd3);
    count_while(1'b1, n);
    check("sn4_rest", n, 15);
    check("sn_missed", missed, 4'b0100);
    missed_clr = 1'b1;
    step();
    missed_clr = 1'b0;

    // ---------------- simultaneous rises ----------------
    alarm_enable = 4'b1010;
    current_time = 8'h20;
    step();
    check("sim_first", alarm_ring, 1'b1);
    check("sim_first_id", ring_id, 2'd1);
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    check("sim_gap", alarm_ring, 1'b0);
    check("sim_gap_id", ring_id, 2'd1);
    step();
    check("sim_second", alarm_ring, 1'b1);
    check("sim_second_id", ring_id, 2'd3);
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    check("sim_done", alarm_ring, 1'b0);
    watch_ring(4, seen);
    check("sim_empty", seen, 1'b0);

    // ---------------- abort paths ----------------
    alarm_enable = 4'b0010;
    current_time = 8'h00;
    step();
    current_time = 8'h20;
    step();
    check("ab_ring", alarm_ring, 1'b1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("ab_snooze", alarm_ring, 1'b0);
    check("ab_cnt", snooze_cnt, 2'd1);
    step();
    step();
    alarm_enable = 4'b0000;
    watch_ring(8, seen);
    check("ab_disable_idle", seen, 1'b0);
    check("ab_no_missed", missed, 4'b0000);
    alarm_enable = 4'b0010;
    step();
    check("ab_reen_ring", alarm_ring, 1'b1);
    check("ab_reen_cnt", snooze_cnt, 2'd0);
    dismiss = 1'b1;
    snooze  = 1'b1;
    step();
    dismiss = 1'b0;
    snooze  = 1'b0;
    check("ab_both_off", alarm_ring, 1'b0);
    check("ab_both_cnt", snooze_cnt, 2'd0);
    watch_ring(8, seen);
    check("ab_both_idle", seen, 1'b0);

    // ---------------- pending cancel ----------------
    alarm_enable = 4'b0101;
    current_time = 8'h75;
    step();
    check("pc_ring", alarm_ring, 1'b1);
    check("pc_id", ring_id, 2'd2);
    current_time = 8'h50;
    step();
    check("pc_still_id", ring_id, 2'd2);
    alarm_enable = 4'b0100;
    step();
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    check("pc_off", alarm_ring, 1'b0);
    watch_ring(5, seen);
    check("pc_ch0_never", seen, 1'b0);
    check("pc_id_hold", ring_id, 2'd2);

    // ---------------- reset mid-operation ----------------
    current_time = 8'h00;
    step();
    current_time = 8'h75;
    step();
    count_while(1'b1, n);
    check("rm_timeout_len", n, 16);
    check("rm_missed", missed, 4'b0100);
    current_time = 8'h00;
    step();
    current_time = 8'h75;
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("rm_in_snooze", snooze_cnt, 2'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rm_ring", alarm_ring, 1'b0);
    check("rm_id", ring_id, 2'd0);
    check("rm_cnt", snooze_cnt, 2'd0);
    check("rm_missed_clr", missed, 4'b0000);
    current_time = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rm_post_idle", alarm_ring, 1'b0);
    current_time = 8'h75;
    step();
    check("rm_new_match", alarm_ring, 1'b1);
    check("rm_new_id", ring_id, 2'd2);
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    watch_ring(20, seen);
    check("rm_held_quiet", seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_alarm_fsm.md
# multi_alarm_fsm

- Parametrised multi-channel alarm controller. Generalises the single-alarm ring/snooze FSM to N independently enabled alarms.
- Adds per-alarm edge-triggered firing, a pending queue, snooze limits, ring timeout and missed-alarm flags.
- Sits between the timekeeping counter, which supplies current_time, and the buzzer/display driver, which consumes alarm_ring and ring_id.

## Interface
- N_ALARMS, 4, number of alarm channels (≥1)
- TIME_W, 8, width of one time value
- SNOOZE_CYC, 5, clock cycles spent in SNOOZE before re-ringing (≥1)
- MAX_SNOOZE, 3, snoozes allowed per ring event (0 = snooze disabled)
- RING_TIMEOUT, 16, max cycles in RINGING before auto-stop (≥2)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- current_time  in  TIME_W  current time from timekeeper
- alarm_time  in  N_ALARMS*TIME_W  packed alarm times; channel i = bits [i*TIME_W +: TIME_W]
- alarm_enable  in  N_ALARMS  per-channel enable
- snooze  in  1  level; sampled each cycle
- dismiss  in  1  level; sampled each cycle
- missed_clr  in  1  clears all missed flags
- alarm_ring  out  1  buzzer drive
- ring_id  out  max(1,$clog2(N_ALARMS))  channel currently ringing/snoozed
- snooze_cnt  out  $clog2(MAX_SNOOZE+1) (min 1)  snoozes used in current event
- missed  out  N_ALARMS  sticky: channel timed out unanswered

## Operation
- raw_match[i] = alarm_enable[i] && (current_time == alarm_time[i]). match_q[i] registers raw_match every cycle.
- A rise, raw_match & ~match_q, marks channel i as firing. A held equality fires exactly once.
- pending[i]: set on a rise. Cleared when channel i is selected to ring, or when alarm_enable[i] = 0. Set has priority over selection clear for other channels only.
- FSM states: IDLE, RINGING, SNOOZE. Single registered timer, cleared on every state entry.
- IDLE:
  - If (pending | rise) is nonzero → RINGING.
  - ring_id = lowest set index. Clear that pending bit. snooze_cnt = 0.
  - snooze and dismiss are ignored.
- RINGING, priority order:
  1. dismiss, or alarm_enable[ring_id] = 0 → IDLE.
  2. snooze && snooze_cnt < MAX_SNOOZE → SNOOZE, snooze_cnt + 1.
  3. timer == RING_TIMEOUT-1 → IDLE, missed[ring_id] set.
  4. Otherwise timer + 1.
  - snooze when snooze_cnt == MAX_SNOOZE is ignored.
- SNOOZE, priority order:
  1. dismiss, or alarm_enable[ring_id] = 0 → IDLE.
  2. timer == SNOOZE_CYC-1 → RINGING, timer cleared, snooze_cnt kept.
  3. Otherwise timer + 1. snooze is ignored.
- New rises while RINGING/SNOOZE only set pending. They are serviced from IDLE in index order, one per event.
- A channel re-firing while it is the active ring_id is queued as a new event.
- missed: sticky per bit. missed_clr clears all bits. Simultaneous set and clear on the same bit → set wins.
- Illegal state encoding → IDLE next cycle.

## Timing
- Reset (rst_n = 0, immediate, mid-operation included):
  - State IDLE, timer 0.
  - alarm_ring 0, ring_id 0, snooze_cnt 0, missed 0.
  - pending 0, match_q 0.
- All outputs decode registered state only. There is no combinational input→output path.
- Match latency: raw_match first true in cycle k, FSM in IDLE → alarm_ring = 1 from cycle k+1.
- Dismiss/snooze latency: sampled at edge, alarm_ring = 0 the following cycle.
- Snooze period: alarm_ring low for exactly SNOOZE_CYC cycles, then high.
- Timeout: with no input, alarm_ring high for exactly RING_TIMEOUT cycles. missed bit visible the cycle alarm_ring drops.
- Back-to-back: a pending channel starts ringing 2 cycles after the prior event ends (one IDLE cycle).
- ring_id holds its last value in IDLE.

## Test plan
- **Basic fire and held match:** N=4, alarm 2 = 0x75 enabled; current_time steps to 0x75 and holds 40 cycles.
  - alarm_ring rises one cycle after match; ring_id = 2.
  - Timeout after 16 cycles sets missed = 4'b0100.
  - No re-ring while the time is held.
- **Snooze limit:** ringing; pulse snooze 4 times, each once ringing resumes.
  - Three low windows of 5 cycles; snooze_cnt goes 1, 2, 3.
  - Fourth snooze is ignored; ring continues to timeout.
- **Simultaneous rises:** channels 1 and 3 match in the same cycle.
  - Channel 1 rings first; dismiss → one IDLE cycle → channel 3 rings.
  - pending empty after.
- **Abort paths:** alarm_enable[ring_id] dropped mid-SNOOZE → IDLE next cycle, no missed bit. Dismiss and snooze asserted together in RINGING → IDLE.
- **Pending cancel:** channel 0 rises while channel 2 rings; disable channel 0 before dismissing 2 → return to IDLE, channel 0 never rings.
- **Reset mid-operation:** rst_n low during SNOOZE with missed = 1 → all outputs 0 immediately. After release, a held match does not fire; a new match does.
